i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter DEVICE_ADDR, default 7'h21: the 7-bit target address this block acknowledges.
REQ-002 Parameter SYNC_STAGES, default 2: the synchronizer depth on scl_i and sda_i, minimum 2.
REQ-003 Port clk_i  input  1: the single system clock; all logic is rising-edge.
REQ-004 Port reset_i  input  1: asynchronous, active-high reset.
REQ-005 Port scl_i  input  1: the bus clock, asynchronous to clk_i.
REQ-006 Port sda_i  input  1: the bus data line, asynchronous to clk_i.
REQ-007 Port sda_oe_o  output  1: 1 pulls SDA low (open-drain); 0 releases it.
REQ-008 Port reg_addr_o  output  8: the register address of the last completed write.
REQ-009 Port reg_data_o  output  8: the data byte of the last completed write.
REQ-010 Port wr_valid_o  output  1: a one-clk_i pulse when reg_addr_o and reg_data_o are updated.
REQ-011 Port busy_o  output  1: high from an accepted START until the next STOP or return to IDLE.
REQ-012 Port error_o  output  1: a one-clk_i pulse on a protocol violation.

Function
REQ-013 scl_i and sda_i SHALL pass through SYNC_STAGES flops; one further registered copy SHALL be kept for edge detection.
REQ-014 START SHALL be detected as synchronized SDA 1->0 while synchronized SCL=1; STOP as SDA 0->1 while SCL=1.
REQ-015 Data bits SHALL be sampled MSB-first on the synchronized SCL rising edge.
REQ-016 The FSM states SHALL be IDLE, ADDR, ACK_ADDR, REG, ACK_REG, DATA, ACK_DATA, WAIT_STOP.
REQ-017 IDLE->ADDR on START; all other bus activity in IDLE SHALL be ignored.
REQ-018 ADDR after 8 bits: if addr[7:1]==DEVICE_ADDR and R/W=0 -> ACK_ADDR; else -> WAIT_STOP with SDA released (NACK), no error.
REQ-019 ACK states SHALL assert sda_oe_o from the SCL falling edge after the 8th bit until the next SCL falling edge.
REQ-020 ACK_ADDR->REG, ACK_REG->DATA, ACK_DATA->WAIT_STOP, each on that second falling edge.
REQ-021 On the 8th sampled DATA bit, reg_addr_o/reg_data_o SHALL update and wr_valid_o SHALL pulse on the same clk_i cycle.
REQ-022 In WAIT_STOP, further bytes SHALL be NACKed (sda_oe_o=0) and ignored.
REQ-023 STOP in any state SHALL go to IDLE with sda_oe_o=0.
REQ-024 A repeated START in any non-IDLE state SHALL go to ADDR and clear the bit counter.
REQ-025 START or STOP with a partial byte (1-7 bits shifted) in ADDR/REG/DATA SHALL pulse error_o and take the REQ-023/024 transition.
REQ-026 START/STOP detection SHALL take priority over bit sampling in the same cycle.
REQ-027 The bit counter SHALL be 3 bits and wrap 7->0 at each byte boundary.
REQ-028 The latency from a raw SCL edge to its internal use SHALL be SYNC_STAGES+1 clk_i cycles.

Reset
REQ-029 On reset_i: state=IDLE, sda_oe_o=0, reg_addr_o=8'h00, reg_data_o=8'h00, wr_valid_o=0, busy_o=0, error_o=0, and the synchronizers load 1 (idle bus).
REQ-030 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously) and discard the partial transfer.

Structure
REQ-031 The state enum type and the I2C_WRITE/I2C_READ bit constants SHALL live in the shared package i2c_pkg, which the i2c master also uses.
REQ-032 The synchronizer plus edge detector SHALL be a sub-module, i2c_bus_sync, instantiated once per line.

Verification
REQ-033 A write with addr 0x42, reg 0x12, data 0x80 at 100 kHz SCL -> three ACKs, wr_valid_o pulses once, reg_addr_o=0x12, reg_data_o=0x80.
REQ-034 Addr 0x44 (wrong device) -> no ACK, wr_valid_o stays 0, error_o stays 0, busy_o clears at STOP.
REQ-035 Addr 0x43 (read) -> NACK at the address ACK, no outputs change.
REQ-036 STOP after 3 bits of REG -> a single error_o pulse, state returns to IDLE, sda_oe_o=0.
REQ-037 A repeated START after ACK_REG, followed by a full write 0x42/0x3A/0x04 -> one wr_valid_o with 0x3A/0x04.
REQ-038 reset_i asserted while sda_oe_o=1 during ACK_ADDR -> sda_oe_o=0 in the same cycle, and all outputs return to their reset values.
REQ-039 The bench SHALL drive the i2c master into this block end-to-end: write_data_i=16'h1280 at device 0x21 -> done_o=1, error_o=0 on the master, and the target captures 0x12/0x80.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both the target and the master.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_REG,
    ST_ACK_REG,
    ST_DATA,
    ST_ACK_DATA,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  // True when an address byte selects device dev for a write.
  function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] dev);
    return (addr_byte[7:1] == dev) && (addr_byte[0] == I2C_WRITE);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizer for one asynchronous bus line, plus a delayed copy for edge detection.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic line_i,
  output logic line_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to 1 so an idle bus does not look like an edge after reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], line_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign line_o = sync_q[STAGES-1];
  assign rise_o = line_o & ~prev_q;
  assign fall_o = ~line_o & prev_q;

endmodule

// File: rtl/i2c_target.sv
// Write-only I2C target: captures one register address/data pair per transfer.
//
// state        | meaning
// ST_IDLE      | bus free, waiting for START
// ST_ADDR      | shifting in the address/RW byte
// ST_ACK_ADDR  | driving ACK for a matching write address
// ST_REG       | shifting in the register address byte
// ST_ACK_REG   | driving ACK for the register byte
// ST_DATA      | shifting in the data byte
// ST_ACK_DATA  | driving ACK for the data byte
// ST_WAIT_STOP | not selected or transfer done; NACK everything until STOP/START
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_data_o,
  output logic       wr_valid_o,
  output logic       busy_o,
  output logic       error_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .line_i  (scl_i),
    .line_o  (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .line_i  (sda_i),
    .line_o  (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] reg_ptr_q, reg_ptr_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_data_q, reg_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_valid_q, wr_valid_d;
  logic       error_q, error_d;

  logic       start_det, stop_det, partial_byte, last_bit;
  logic [7:0] byte_in;

  assign start_det    = sda_fall & scl_lvl;
  assign stop_det     = sda_rise & scl_lvl;
  assign partial_byte = (state_q inside {ST_ADDR, ST_REG, ST_DATA}) && (bit_cnt_q != 3'd0);
  assign byte_in      = {shift_q, sda_lvl};
  assign last_bit     = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    reg_ptr_d  = reg_ptr_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    error_d    = 1'b0;

    // Bus conditions win over any bit sampled in the same cycle.
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      error_d   = partial_byte;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      error_d   = partial_byte;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_REG, ST_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              unique case (state_q)
                ST_ADDR: state_d = addr_hit(byte_in, DEVICE_ADDR) ? ST_ACK_ADDR : ST_WAIT_STOP;
                ST_REG: begin
                  reg_ptr_d = byte_in;
                  state_d   = ST_ACK_REG;
                end
                default: begin
                  reg_addr_d = reg_ptr_q;
                  reg_data_d = byte_in;
                  wr_valid_d = 1'b1;
                  state_d    = ST_ACK_DATA;
                end
              endcase
            end
          end
        end

        // First SCL fall after the 8th bit starts driving ACK, the second ends it.
        ST_ACK_ADDR, ST_ACK_REG, ST_ACK_DATA: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              unique case (state_q)
                ST_ACK_ADDR: state_d = ST_REG;
                ST_ACK_REG:  state_d = ST_DATA;
                default:     state_d = ST_WAIT_STOP;
              endcase
            end
          end
        end

        ST_WAIT_STOP: sda_oe_d = 1'b0;

        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
          sda_oe_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'h00;
      reg_ptr_q  <= 8'h00;
      reg_addr_q <= 8'h00;
      reg_data_q <= 8'h00;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      reg_ptr_q  <= reg_ptr_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      error_q    <= error_d;
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign reg_addr_o = reg_addr_q;
  assign reg_data_o = reg_data_q;
  assign wr_valid_o = wr_valid_q;
  assign error_o    = error_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bus-level master and a transaction model of what the target must do.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam logic [6:0] DEV = 7'h21;
  localparam int Q = 25;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe_o, wr_valid_o, busy_o, error_o;
  logic [7:0] reg_addr_o, reg_data_o;

  assign sda_bus = sda_m & ~sda_oe_o;

  i2c_target #(.DEVICE_ADDR(DEV), .SYNC_STAGES(2)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .scl_i      (scl),
    .sda_i      (sda_bus),
    .sda_oe_o   (sda_oe_o),
    .reg_addr_o (reg_addr_o),
    .reg_data_o (reg_data_o),
    .wr_valid_o (wr_valid_o),
    .busy_o     (busy_o),
    .error_o    (error_o)
  );

  always #50 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: byte index since START, selection, partial bit count.
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t        exp_q[$];
  int         idx = 0;
  logic       sel = 1'b0;
  logic [7:0] ptr = 8'h00;
  int         partial = 0;
  int         exp_err = 0;
  int         err_seen = 0;
  int         wr_seen = 0;
  logic [7:0] mdl_addr = 8'h00;
  logic [7:0] mdl_data = 8'h00;
  logic       ack_allowed = 1'b0;

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (wr_valid_o) begin
        wr_seen++;
        check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mdl_addr = exp_q[0].a;
          mdl_data = exp_q[0].d;
          void'(exp_q.pop_front());
          check("wr_reg_addr", 32'(reg_addr_o), 32'(mdl_addr));
          check("wr_reg_data", 32'(reg_data_o), 32'(mdl_data));
        end
      end else begin
        check("reg_addr_hold", 32'(reg_addr_o), 32'(mdl_addr));
        check("reg_data_hold", 32'(reg_data_o), 32'(mdl_data));
      end
      if (sda_oe_o) check("sda_oe_window", 32'(ack_allowed), 32'd1);
      if (error_o) err_seen++;
    end
  end

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  function automatic logic err_due();
    return (partial > 0) && ((idx == 0) || (sel && idx <= 2));
  endfunction

  // A START from SCL low needs an SCL rise first, which the target samples as a bit.
  task automatic bus_start();
    if (scl == 1'b0) begin
      sda_m = 1'b1; wait_q(Q); scl = 1'b1; partial++; wait_q(Q);
    end
    if (err_due()) exp_err++;
    idx = 0; sel = 1'b0; partial = 0;
    sda_m = 1'b0; wait_q(Q); scl = 1'b0; wait_q(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q(Q); scl = 1'b1; partial++; wait_q(Q);
    if (err_due()) exp_err++;
    sda_m = 1'b1; wait_q(Q);
    idx = 0; sel = 1'b0; partial = 0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sda_m = v[7-i]; wait_q(Q); scl = 1'b1; wait_q(2*Q); scl = 1'b0; wait_q(Q);
      partial++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic exp_ack;
    exp_ack = (idx == 0) ? (b == {DEV, I2C_WRITE}) : (sel && idx <= 2);
    if (idx == 0) sel = exp_ack;
    if (idx == 1) ptr = b;
    if (idx == 2 && sel) exp_q.push_back('{a: ptr, d: b});
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_q(Q); scl = 1'b1; wait_q(2*Q);
      if (i == 0) ack_allowed = 1'b1;
      scl = 1'b0; wait_q(Q);
    end
    sda_m = 1'b1; wait_q(Q); scl = 1'b1; wait_q(Q);
    ack = ~sda_bus;
    wait_q(Q); scl = 1'b0; wait_q(10); ack_allowed = 1'b0; wait_q(Q-10);
    idx++; partial = 0;
    check("ack_byte", 32'(ack), 32'(exp_ack));
  endtask

  task automatic i2c_master_write(input logic [6:0] dev, input logic [15:0] wdata,
                                  output logic done, output logic err);
    logic a0, a1, a2;
    bus_start();
    send_byte({dev, I2C_WRITE}, a0);
    send_byte(wdata[15:8], a1);
    send_byte(wdata[7:0], a2);
    bus_stop();
    done = 1'b1;
    err  = ~(a0 & a1 & a2);
  endtask

  task automatic write3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic ack;
    bus_start();
    check("busy_after_start", 32'(busy_o), 32'd1);
    send_byte(b0, ack);
    send_byte(b1, ack);
    send_byte(b2, ack);
    bus_stop();
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   wr0, err0;
    logic ack, done, merr;

    // Reset values
    wait_q(5);
    check("rst_sda_oe", 32'(sda_oe_o), 32'd0);
    check("rst_reg_addr", 32'(reg_addr_o), 32'h00);
    check("rst_reg_data", 32'(reg_data_o), 32'h00);
    check("rst_wr_valid", 32'(wr_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    reset_i = 1'b0;
    wait_q(10);
    check("idle_busy", 32'(busy_o), 32'd0);

    // Basic write 0x42 / 0x12 / 0x80
    wr0 = wr_seen; err0 = err_seen;
    write3(8'h42, 8'h12, 8'h80);
    wait_q(5);
    check("w1_busy_clear", 32'(busy_o), 32'd0);
    check("w1_wr_count", 32'(wr_seen - wr0), 32'd1);
    check("w1_reg_addr", 32'(reg_addr_o), 32'h12);
    check("w1_reg_data", 32'(reg_data_o), 32'h80);
    check("w1_no_error", 32'(err_seen - err0), 32'd0);

    // Wrong device 0x44
    wr0 = wr_seen; err0 = err_seen;
    write3(8'h44, 8'h12, 8'h34);
    wait_q(5);
    check("wrong_dev_busy_clear", 32'(busy_o), 32'd0);
    check("wrong_dev_wr_count", 32'(wr_seen - wr0), 32'd0);
    check("wrong_dev_error", 32'(err_seen - err0), 32'd0);

    // Read request 0x43
    wr0 = wr_seen;
    bus_start();
    send_byte({DEV, I2C_READ}, ack);
    check("read_nack", 32'(ack), 32'd0);
    send_byte(8'h99, ack);
    bus_stop();
    wait_q(5);
    check("read_wr_count", 32'(wr_seen - wr0), 32'd0);
    check("read_reg_addr", 32'(reg_addr_o), 32'h12);
    check("read_reg_data", 32'(reg_data_o), 32'h80);

    // STOP after 3 bits of the register byte
    err0 = err_seen;
    bus_start();
    send_byte(8'h42, ack);
    send_bits(8'hA0, 3);
    bus_stop();
    wait_q(5);
    check("partial_stop_error", 32'(err_seen - err0), 32'd1);
    check("partial_stop_busy", 32'(busy_o), 32'd0);
    check("partial_stop_sda_oe", 32'(sda_oe_o), 32'd0);

    // Repeated START after the register ACK, then a full write
    wr0 = wr_seen;
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h55, ack);
    write3(8'h42, 8'h3A, 8'h04);
    wait_q(5);
    check("rstart_wr_count", 32'(wr_seen - wr0), 32'd1);
    check("rstart_reg_addr", 32'(reg_addr_o), 32'h3A);
    check("rstart_reg_data", 32'(reg_data_o), 32'h04);

    // Repeated START after 5 bits of DATA
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h77, ack);
    send_bits(8'hF0, 5);
    write3(8'h42, 8'h01, 8'h02);
    wait_q(5);
    check("rstart_data_reg_addr", 32'(reg_addr_o), 32'h01);
    check("rstart_data_reg_data", 32'(reg_data_o), 32'h02);

    check("error_total", 32'(err_seen), 32'(exp_err));
    check("model_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while ACK_ADDR drives SDA
    bus_start();
    ack_allowed = 1'b1;
    send_bits(8'h42, 8);
    wait_q(10);
    check("ack_addr_drive", 32'(sda_oe_o), 32'd1);
    #10;
    exp_q.delete();
    mdl_addr = 8'h00; mdl_data = 8'h00;
    reset_i = 1'b1;
    #1;
    check("async_rst_sda_oe", 32'(sda_oe_o), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_reg_addr", 32'(reg_addr_o), 32'h00);
    check("async_rst_reg_data", 32'(reg_data_o), 32'h00);
    check("async_rst_wr_valid", 32'(wr_valid_o), 32'd0);
    check("async_rst_error", 32'(error_o), 32'd0);
    wait_q(3); sda_m = 1'b1; wait_q(2); scl = 1'b1; wait_q(5);
    ack_allowed = 1'b0;
    idx = 0; sel = 1'b0; partial = 0;
    reset_i = 1'b0;
    wait_q(10);
    check("post_rst_busy", 32'(busy_o), 32'd0);

    // End-to-end master write
    done = 1'b0; merr = 1'b1;
    i2c_master_write(DEV, 16'h1280, done, merr);
    wait_q(5);
    check("master_done", 32'(done), 32'd1);
    check("master_error", 32'(merr), 32'd0);
    check("master_reg_addr", 32'(reg_addr_o), 32'h12);
    check("master_reg_data", 32'(reg_data_o), 32'h80);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
